// File: rtl/fbuf_writer.sv
// fbuf_writer -- write-side engine for the 512x16 scan-out framebuffer.
//
// Runs Chip-8/SCHIP clear-screen and DXYN sprite draws. Each sprite row is
// turned into a 32-bit mask spanning up to two framebuffer words. Every
// touched word gets a read-modify-write XOR. Any lit pixel that the draw
// turns off sets the collision flag, which the CPU copies into VF.
//
// Ports
//   clk, res            clock, asynchronous active-low reset
//   hires               1 = 128x64 layout (8 words/row), 0 = 64x32 (4 words/row)
//   cmd_cls, cmd_draw   command strobes, only sampled while idle (cls wins)
//   draw_x/y/n          sprite origin and row count (n == 0 -> 16x16 sprite)
//   spr_req/spr_row     one-cycle request for one sprite row
//   spr_valid/spr_data  sprite row return (latency >= 1)
//   fbuf_addr/rdata     framebuffer read (rdata valid 1 cycle after addr)
//   fbuf_wdata/we       framebuffer write
//   vblank              display blanking; only used with FBUF_VBLANK_WAIT_EN
//   busy, done          command in progress / one-cycle completion pulse
//   collision           sticky until the next command starts
//
// Build option: define FBUF_VBLANK_WAIT_EN to hold each accepted command in
// WAIT_VB until vblank is high, so framebuffer updates never tear.
module fbuf_writer #(
  parameter int FB_AW = 9,
  parameter int FB_DW = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             hires,
  input  logic             cmd_cls,
  input  logic             cmd_draw,
  input  logic [6:0]       draw_x,
  input  logic [5:0]       draw_y,
  input  logic [3:0]       draw_n,
  output logic             spr_req,
  output logic [3:0]       spr_row,
  input  logic             spr_valid,
  input  logic [15:0]      spr_data,
  output logic [FB_AW-1:0] fbuf_addr,
  input  logic [FB_DW-1:0] fbuf_rdata,
  output logic [FB_DW-1:0] fbuf_wdata,
  output logic             fbuf_we,
  input  logic             vblank,
  output logic             busy,
  output logic             done,
  output logic             collision
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CLR      = 4'd1;
  localparam logic [3:0] S_ROW_REQ  = 4'd2;
  localparam logic [3:0] S_ROW_WAIT = 4'd3;
  localparam logic [3:0] S_RD       = 4'd4;
  localparam logic [3:0] S_RD_WAIT  = 4'd5;
  localparam logic [3:0] S_WR       = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
`ifdef FBUF_VBLANK_WAIT_EN
  localparam logic [3:0] S_WAIT_VB  = 4'd8;
`endif

  logic [3:0]       r_state;
  logic             r_busy, r_done, r_coll, r_spr_req, r_we;
  logic             r_w16;    // 16-wide sprite (draw_n == 0)
  logic             r_half;   // 0 = left (hi) word of the row mask, 1 = right (lo)
  logic [FB_AW-1:0] r_addr;
  logic [FB_DW-1:0] r_wdata;
  logic [6:0]       r_x;      // already wrapped to the layout width
  logic [5:0]       r_y;      // already wrapped to the layout height
  logic [4:0]       r_row, r_nrows;
  logic [31:0]      r_mask;
`ifdef FBUF_VBLANK_WAIT_EN
  logic             r_is_cls;
`else
  logic             w_unused;
  assign w_unused = vblank;
`endif

  logic [6:0]       w_yr;
  logic             w_clip;
  logic [3:0]       w_wpr, w_col0, w_col1;
  logic [15:0]      w_pix, w_mhalf;
  logic [31:0]      w_mask_new;
  logic             w_hi_ok_new, w_lo_ok_new, w_lo_ok;
  logic [8:0]       w_rowbase;
  logic [FB_AW-1:0] w_addr_hi, w_addr_lo, w_clr_last;

  // Screen row of the current sprite row; 7 bits so bottom clipping is visible.
  assign w_yr   = {1'b0, r_y} + {2'b00, r_row};
  assign w_clip = w_yr >= (hires ? 7'd64 : 7'd32);
  assign w_wpr  = hires ? 4'd8 : 4'd4;
  assign w_col0 = {1'b0, r_x[6:4]};
  assign w_col1 = w_col0 + 4'd1;

  // 8-wide sprites use only the upper byte of the row.
  assign w_pix      = r_w16 ? spr_data : {spr_data[15:8], 8'h00};
  assign w_mask_new = {w_pix, 16'h0000} >> r_x[3:0];

  // A word is skipped if none of its pixels are set, or if it lies past the right edge.
  assign w_hi_ok_new = (|w_mask_new[31:16]) && (w_col0 < w_wpr);
  assign w_lo_ok_new = (|w_mask_new[15:0])  && (w_col1 < w_wpr);
  assign w_lo_ok     = (|r_mask[15:0])      && (w_col1 < w_wpr);
  assign w_mhalf     = r_half ? r_mask[15:0] : r_mask[31:16];

  assign w_rowbase  = hires ? {w_yr[5:0], 3'b000} : {2'b00, w_yr[4:0], 2'b00};
  assign w_addr_hi  = FB_AW'(w_rowbase + {5'b00000, w_col0});
  assign w_addr_lo  = FB_AW'(w_rowbase + {5'b00000, w_col1});
  assign w_clr_last = FB_AW'(hires ? 9'd511 : 9'd127);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_coll    <= 1'b0;
      r_spr_req <= 1'b0;
      r_we      <= 1'b0;
      r_w16     <= 1'b0;
      r_half    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_row     <= '0;
      r_nrows   <= '0;
      r_mask    <= '0;
`ifdef FBUF_VBLANK_WAIT_EN
      r_is_cls  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_cls || cmd_draw) begin
            r_busy  <= 1'b1;
            r_coll  <= 1'b0;
            r_x     <= hires ? draw_x : {1'b0, draw_x[5:0]};
            r_y     <= hires ? draw_y : {1'b0, draw_y[4:0]};
            r_nrows <= (draw_n == 4'd0) ? 5'd16 : {1'b0, draw_n};
            r_w16   <= (draw_n == 4'd0);
            r_row   <= '0;
`ifdef FBUF_VBLANK_WAIT_EN
            r_is_cls <= cmd_cls;
            r_state  <= S_WAIT_VB;
`else
            if (cmd_cls) begin
              r_addr  <= '0;
              r_wdata <= '0;
              r_we    <= 1'b1;
              r_state <= S_CLR;
            end else begin
              r_state <= S_ROW_REQ;
            end
`endif
          end
        end
`ifdef FBUF_VBLANK_WAIT_EN
        S_WAIT_VB: begin
          if (vblank) begin
            if (r_is_cls) begin
              r_addr  <= '0;
              r_wdata <= '0;
              r_we    <= 1'b1;
              r_state <= S_CLR;
            end else begin
              r_state <= S_ROW_REQ;
            end
          end
        end
`endif
        S_CLR: begin
          if (r_addr == w_clr_last) begin
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_ROW_REQ: begin
          // Once one row is clipped, every later row is clipped too.
          if (r_row == r_nrows || w_clip) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_spr_req <= 1'b1;
            r_state   <= S_ROW_WAIT;
          end
        end
        S_ROW_WAIT: begin
          r_spr_req <= 1'b0;
          if (spr_valid) begin
            r_mask <= w_mask_new;
            if (w_hi_ok_new) begin
              r_half  <= 1'b0;
              r_addr  <= w_addr_hi;
              r_state <= S_RD;
            end else if (w_lo_ok_new) begin
              r_half  <= 1'b1;
              r_addr  <= w_addr_lo;
              r_state <= S_RD;
            end else begin
              r_row   <= r_row + 5'd1;
              r_state <= S_ROW_REQ;
            end
          end
        end
        S_RD: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          r_wdata <= fbuf_rdata ^ w_mhalf;
          r_coll  <= r_coll | (|(fbuf_rdata & w_mhalf));
          r_we    <= 1'b1;
          r_state <= S_WR;
        end
        S_WR: begin
          r_we <= 1'b0;
          if (!r_half && w_lo_ok) begin
            r_half  <= 1'b1;
            r_addr  <= w_addr_lo;
            r_state <= S_RD;
          end else begin
            r_row   <= r_row + 5'd1;
            r_state <= S_ROW_REQ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spr_req    = r_spr_req;
  assign spr_row    = r_row[3:0];
  assign fbuf_addr  = r_addr;
  assign fbuf_wdata = r_wdata;
  assign fbuf_we    = r_we;
  assign busy       = r_busy;
  assign done       = r_done;
  assign collision  = r_coll;

endmodule
